// File: rtl/fft4_packer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft4_packer_if : serial sample stream in, 4-lane frame handshake out
// Revision 1.0
// ---------------------------------------------------------------------------
interface fft4_packer_if #(
  parameter int NB_DATA = 8
);
  logic [2*NB_DATA-1:0] i_data;
  logic                 i_valid;
  logic                 i_sof;
  logic                 o_ready;
  logic [2*NB_DATA-1:0] o_x0;
  logic [2*NB_DATA-1:0] o_x1;
  logic [2*NB_DATA-1:0] o_x2;
  logic [2*NB_DATA-1:0] o_x3;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_err;

  modport slave (
    input  i_data, i_valid, i_sof, i_ready,
    output o_ready, o_x0, o_x1, o_x2, o_x3, o_valid, o_err
  );

  modport master (
    output i_data, i_valid, i_sof, i_ready,
    input  o_ready, o_x0, o_x1, o_x2, o_x3, o_valid, o_err
  );
endinterface
`default_nettype wire

// File: rtl/fft4_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft4_packer : ping-pong serial-to-parallel packer, 4 samples per frame
// Revision 1.0
// ---------------------------------------------------------------------------
module fft4_packer #(
  parameter int NB_DATA = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fft4_packer_if.slave  bus
);
  localparam int         NB_SAMPLE = 2 * NB_DATA;
  localparam logic [1:0] LAST_LANE = 2'd3;

  // Lane storage indexed {buffer, lane}
  logic [NB_SAMPLE-1:0] r_lane [0:7];
  logic [1:0]           r_full;
  logic                 r_wr_sel;
  logic                 r_rd_sel;
  logic [1:0]           r_wr_idx;
  logic                 r_err;

  logic                 w_ready;
  logic                 w_accept;
  logic [1:0]           w_lane;
  logic                 w_done;
  logic                 w_rd_fire;
  logic [1:0]           w_full_nxt;

  assign w_ready   = ~r_full[r_wr_sel] & ~i_rst;
  assign w_accept  = bus.i_valid & w_ready;
  assign w_lane    = bus.i_sof ? 2'd0 : r_wr_idx;
  assign w_done    = w_accept & (w_lane == LAST_LANE);
  assign w_rd_fire = r_full[r_rd_sel] & bus.i_ready;

  // A buffer being completed is never the one being read, so the bits differ
  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_fire) w_full_nxt[r_rd_sel] = 1'b0;
    if (w_done)    w_full_nxt[r_wr_sel] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < 8; k++) r_lane[k] <= '0;
      r_full   <= 2'b00;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_wr_idx <= 2'd0;
      r_err    <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      r_err  <= w_accept & bus.i_sof & (r_wr_idx != 2'd0);
      if (w_accept) begin
        r_lane[{r_wr_sel, w_lane}] <= bus.i_data;
        r_wr_idx <= w_lane + 2'd1;
      end
      if (w_done)    r_wr_sel <= ~r_wr_sel;
      if (w_rd_fire) r_rd_sel <= ~r_rd_sel;
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_valid = r_full[r_rd_sel];
  assign bus.o_err   = r_err;
  assign bus.o_x0    = r_lane[{r_rd_sel, 2'd0}];
  assign bus.o_x1    = r_lane[{r_rd_sel, 2'd1}];
  assign bus.o_x2    = r_lane[{r_rd_sel, 2'd2}];
  assign bus.o_x3    = r_lane[{r_rd_sel, 2'd3}];
endmodule
`default_nettype wire

// File: tb/tb_fft4_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fft4_packer : directed + random stimulus against a frame-queue model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_fft4_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  fft4_packer_if #(.NB_DATA(8)) bus ();

  fft4_packer #(.NB_DATA(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: accepted samples gather in part; four make a frame in q
  logic [15:0] part[$];
  logic [63:0] q[$];
  logic        err_exp = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_clear();
    part.delete();
    q.delete();
    err_exp = 1'b0;
  endtask

  task automatic cycle(input logic v, input logic s, input logic [15:0] d,
                       input logic r, output logic acc);
    logic exp_valid;
    logic exp_ready;
    bus.i_valid = v;
    bus.i_sof   = s;
    bus.i_data  = d;
    bus.i_ready = r;
    @(negedge clk);
    exp_valid = (q.size() > 0);
    exp_ready = (q.size() < 2);
    check("o_valid", 64'(bus.o_valid), 64'(exp_valid));
    check("o_ready", 64'(bus.o_ready), 64'(exp_ready));
    check("o_err",   64'(bus.o_err),   64'(err_exp));
    if (exp_valid)
      check("lanes", {bus.o_x0, bus.o_x1, bus.o_x2, bus.o_x3}, q[0]);
    acc = v && exp_ready;
    if (exp_valid && r) void'(q.pop_front());
    err_exp = 1'b0;
    if (acc) begin
      if (s) begin
        if (part.size() != 0) err_exp = 1'b1;
        part.delete();
      end
      part.push_back(d);
      if (part.size() == 4) begin
        q.push_back({part[0], part[1], part[2], part[3]});
        part.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic s, input logic r);
    logic acc;
    int   n;
    n = 0;
    do begin
      cycle(1'b1, s, d, r, acc);
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      n_total++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted data=%h", d);
    end
  endtask

  task automatic idle(input int n, input logic r);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, r, acc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(bus.o_valid), 64'd0);
    check("rst_ready", 64'(bus.o_ready), 64'd0);
    check("rst_err",   64'(bus.o_err),   64'd0);
    check("rst_lanes", {bus.o_x0, bus.o_x1, bus.o_x2, bus.o_x3}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();

    // Basic frame
    send(16'h0101, 1'b0, 1'b1);
    send(16'h0202, 1'b0, 1'b1);
    send(16'h0303, 1'b0, 1'b1);
    send(16'h0404, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Backpressure: two frames fill both buffers, third frame stalls
    for (int i = 1; i <= 8; i++) send(16'(i * 16'h0111), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0999, 1'b0, acc);
    for (int i = 9; i <= 12; i++) send(16'(i * 16'h0111), 1'b0, 1'b1);
    idle(4, 1'b1);

    // Resync: A, B abandoned by SOF on C
    send(16'h00AA, 1'b0, 1'b1);
    send(16'h00BB, 1'b0, 1'b1);
    send(16'h00CC, 1'b1, 1'b1);
    send(16'h00DD, 1'b0, 1'b1);
    send(16'h00EE, 1'b0, 1'b1);
    send(16'h00FF, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Streaming 0..63 at full rate
    for (int i = 0; i < 64; i++) send(16'(i), 1'b0, 1'b1);
    idle(3, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 11) == 0),
            16'($urandom), 1'($urandom_range(0, 2) != 0), acc);
    idle(4, 1'b1);
    if (part.size() != 0) send(16'h5A5A, 1'b1, 1'b1);
    while (part.size() != 0) send(16'h1234, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Reset mid-frame with one frame pending
    for (int i = 0; i < 6; i++) send(16'(16'hC000 + i), 1'b0, 1'b0);
    bus.i_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("mrst_valid", 64'(bus.o_valid), 64'd0);
    check("mrst_ready", 64'(bus.o_ready), 64'd0);
    check("mrst_err",   64'(bus.o_err),   64'd0);
    check("mrst_lanes", {bus.o_x0, bus.o_x1, bus.o_x2, bus.o_x3}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    send(16'h7001, 1'b0, 1'b1);
    send(16'h7002, 1'b0, 1'b1);
    send(16'h7003, 1'b0, 1'b1);
    send(16'h7004, 1'b0, 1'b1);
    idle(4, 1'b1);
    check("final_queue_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
